// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared hazard-control types and width defaults.
// Also imported by the forwarding and datapath blocks.
package pipeline_hazard_controller_pkg;

  localparam int DEF_REG_ADDR_W  = 3;
  localparam int DEF_STALL_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10,
    MEMWAIT = 2'b11
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline and the controller.
// master = pipeline side, slave = hazard controller side.
interface pipeline_hazard_controller_if
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
);

  logic [REG_ADDR_W-1:0]  If_Id_r1Address;
  logic [REG_ADDR_W-1:0]  If_Id_r2Address;
  logic                   If_Id_usesR1;
  logic                   If_Id_usesR2;
  logic [REG_ADDR_W-1:0]  Id_Ex_dest;
  logic                   Id_Ex_memRead;
  logic                   Id_Ex_regWrite;
  logic                   branchTaken;
  logic                   memBusy;
  logic                   pcWrite;
  logic                   If_Id_write;
  logic                   If_Id_flush;
  logic                   Id_Ex_bubble;
  logic                   pipeHold;
  logic [1:0]             hazardState;
  logic [STALL_CNT_W-1:0] stallCycles;

  modport master (
    output If_Id_r1Address, If_Id_r2Address,
    output If_Id_usesR1, If_Id_usesR2,
    output Id_Ex_dest, Id_Ex_memRead,
    output Id_Ex_regWrite, branchTaken,
    output memBusy,
    input  pcWrite, If_Id_write, If_Id_flush,
    input  Id_Ex_bubble, pipeHold,
    input  hazardState, stallCycles
  );

  modport slave (
    input  If_Id_r1Address, If_Id_r2Address,
    input  If_Id_usesR1, If_Id_usesR2,
    input  Id_Ex_dest, Id_Ex_memRead,
    input  Id_Ex_regWrite, branchTaken,
    input  memBusy,
    output pcWrite, If_Id_write, If_Id_flush,
    output Id_Ex_bubble, pipeHold,
    output hazardState, stallCycles
  );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use comparator: EX load feeding a
// source register of the instruction in decode.
module load_use_detector
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] r1,
  input  logic [REG_ADDR_W-1:0] r2,
  input  logic                  uses_r1,
  input  logic                  uses_r2,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  mem_read,
  input  logic                  reg_write,
  output logic                  load_use
);

  logic hit1;
  logic hit2;

  assign hit1 = uses_r1 && (dest == r1);
  assign hit2 = uses_r2 && (dest == r2);

  assign load_use = mem_read && reg_write
                 && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard FSM (Mealy) plus saturating stall counter;
// stalls, flushes and memory holds for a 5-stage pipe.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_hazard_controller_if.slave  hz
);

  hz_state_t              state;
  hz_state_t              next;
  logic                   load_use;
  logic                   lu_en;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   flush;
  logic                   bubble;
  logic                   hold;
  logic [STALL_CNT_W-1:0] cnt;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lud (
    .r1        (hz.If_Id_r1Address),
    .r2        (hz.If_Id_r2Address),
    .uses_r1   (hz.If_Id_usesR1),
    .uses_r2   (hz.If_Id_usesR2),
    .dest      (hz.Id_Ex_dest),
    .mem_read  (hz.Id_Ex_memRead),
    .reg_write (hz.Id_Ex_regWrite),
    .load_use  (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next;
  end

  // LDSTALL and FLUSH mask loadUse; MEMWAIT releases as RUN.
  assign lu_en = (state == RUN) || (state == MEMWAIT);

  always_comb begin
    next       = RUN;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush      = 1'b0;
    bubble     = 1'b0;
    hold       = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end else begin
      priority case (1'b1)
        hz.memBusy: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          hold       = 1'b1;
          next       = MEMWAIT;
        end
        hz.branchTaken: begin
          flush  = 1'b1;
          bubble = 1'b1;
          next   = FLUSH;
        end
        (load_use && lu_en): begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          next       = LDSTALL;
        end
        default: next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!pc_write && (cnt != '1))
      cnt <= cnt + STALL_CNT_W'(1);
  end

  assign hz.pcWrite      = pc_write;
  assign hz.If_Id_write  = ifid_write;
  assign hz.If_Id_flush  = flush;
  assign hz.Id_Ex_bubble = bubble;
  assign hz.pipeHold     = hold;
  assign hz.hazardState  = state;
  assign hz.stallCycles  = cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_controller;

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_HOLD  = 5'b00001;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_LD    = 2'b01;
  localparam logic [1:0] S_FL    = 2'b10;
  localparam logic [1:0] S_MW    = 2'b11;

  typedef struct {
    string      nm;
    logic [4:0] o;
    logic [1:0] st;
    int         sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   sc = 0;
  exp_t q[$];

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] r1, r2,
                        input logic u1, u2,
                        input logic [2:0] d,
                        input logic mr, rw, bt, mb);
    hz.If_Id_r1Address = r1;
    hz.If_Id_r2Address = r2;
    hz.If_Id_usesR1    = u1;
    hz.If_Id_usesR2    = u2;
    hz.Id_Ex_dest      = d;
    hz.Id_Ex_memRead   = mr;
    hz.Id_Ex_regWrite  = rw;
    hz.branchTaken     = bt;
    hz.memBusy         = mb;
  endtask

  task automatic step(input string nm,
                      input logic [2:0] r1, r2,
                      input logic u1, u2,
                      input logic [2:0] d,
                      input logic mr, rw, bt, mb,
                      input logic [4:0] o,
                      input logic [1:0] st);
    @(posedge clk);
    #1;
    set_in(r1, r2, u1, u2, d, mr, rw, bt, mb);
    q.push_back('{nm, o, st, sc});
    if (!o[4]) sc = (sc == 255) ? 255 : sc + 1;
  endtask

  task automatic idle(input string nm, input logic [1:0] st);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, st);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".out"},
          {hz.pcWrite, hz.If_Id_write, hz.If_Id_flush,
           hz.Id_Ex_bubble, hz.pipeHold}, e.o);
      chk({e.nm, ".st"}, hz.hazardState, e.st);
      chk({e.nm, ".cnt"}, hz.stallCycles, e.sc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst0.pcw", hz.pcWrite, 0);
    chk("rst0.ifw", hz.If_Id_write, 0);
    chk("rst0.fl", hz.If_Id_flush, 0);
    chk("rst0.bub", hz.Id_Ex_bubble, 1);
    chk("rst0.hold", hz.pipeHold, 0);
    chk("rst0.st", hz.hazardState, 0);
    chk("rst0.cnt", hz.stallCycles, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    q.push_back('{"post_rst0", O_RUN, S_RUN, 0});

    idle("idle", S_RUN);
    step("lu", 3, 0, 1, 0, 3, 1, 1, 0, 0, O_STALL, S_RUN);
    step("lu_mask", 3, 0, 1, 0, 3, 1, 1, 0, 0, O_RUN, S_LD);
    idle("lu_ret", S_RUN);
    step("nh_u1", 3, 0, 0, 0, 3, 1, 1, 0, 0, O_RUN, S_RUN);
    step("nh_mr", 3, 0, 1, 0, 3, 0, 1, 0, 0, O_RUN, S_RUN);
    step("nh_rw", 3, 0, 1, 0, 3, 1, 0, 0, 0, O_RUN, S_RUN);
    step("nh_ad", 3, 0, 1, 0, 2, 1, 1, 0, 0, O_RUN, S_RUN);
    step("lu_r2", 0, 5, 0, 1, 5, 1, 1, 0, 0, O_STALL, S_RUN);
    idle("lu_r2m", S_LD);

    step("br_lu", 3, 0, 1, 0, 3, 1, 1, 1, 0, O_FLUSH, S_RUN);
    step("fl_mask", 3, 0, 1, 0, 3, 1, 1, 0, 0, O_RUN, S_FL);
    idle("fl_ret", S_RUN);
    step("ld_br", 4, 0, 1, 0, 4, 1, 1, 0, 0, O_STALL, S_RUN);
    step("ld_br2", 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH, S_LD);
    idle("ld_br3", S_FL);

    step("mw0", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, S_RUN);
    step("mw1", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, S_MW);
    step("mw2", 3, 0, 1, 0, 3, 1, 1, 1, 1, O_HOLD, S_MW);
    step("mw3", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, S_MW);
    idle("mw_rel", S_MW);
    idle("mw_run", S_RUN);
    step("mb_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, O_HOLD, S_RUN);
    step("mw_brl", 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH, S_MW);
    idle("mw_brf", S_FL);
    step("mw_lu0", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, S_RUN);
    step("mw_lu1", 6, 0, 1, 0, 6, 1, 1, 0, 0, O_STALL, S_MW);
    idle("mw_lu2", S_LD);

    step("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, S_RUN);
    step("mw_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, S_MW);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.st", hz.hazardState, 0);
    chk("arst.cnt", hz.stallCycles, 0);
    chk("arst.bub", hz.Id_Ex_bubble, 1);
    chk("arst.pcw", hz.pcWrite, 0);
    chk("arst.hold", hz.pipeHold, 0);
    sc = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.push_back('{"post_rst1", O_RUN, S_RUN, 0});

    for (int i = 0; i < 300; i++)
      step("sat", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD,
           (i == 0) ? S_RUN : S_MW);
    idle("sat_rel", S_MW);
    idle("sat_run", S_RUN);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    chk("q_drain", q.size(), 0);
    #1;
    chk("sat_hold", hz.stallCycles, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
